// File: rtl/io_entry_ctrl_pkg.sv
// Shared types and helpers for the user-I/O entry front end.
package io_entry_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    BUSY  = 2'b11
  } mode_e;

  // Request op codes share the mode encoding.
  typedef mode_e op_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    REQ,
    WAIT,
    SHOW
  } state_e;

  // Mode rotation used by mode_key while idle.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      CLEAR:   return WRITE;
      WRITE:   return READ;
      default: return CLEAR;
    endcase
  endfunction

  // Number of real bits carried by hex digit idx of a total_w-bit value (0..4).
  function automatic int digit_bits(input int total_w, input int idx);
    int rem;
    rem = total_w - 4 * idx;
    if (rem <= 0) return 0;
    if (rem >= 4) return 4;
    return rem;
  endfunction

  // Largest value a digit may hold before wrapping to 0.
  function automatic logic [3:0] digit_maxv(input int total_w, input int idx);
    return 4'((1 << digit_bits(total_w, idx)) - 1);
  endfunction

endpackage

// File: rtl/io_entry_ctrl_hex_digit_ctr.sv
// One hex digit of an entry register: increments on en, wraps past MAXV to 0,
// synchronous clear has priority over increment.
module hex_digit_ctr #(
  parameter logic [3:0] MAXV = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] val
);

  logic [3:0] val_q;
  logic [3:0] val_d;

  // Next digit value: clear, wrap-increment or hold.
  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = 4'h0;
    end else if (en) begin
      val_d = (val_q >= MAXV) ? 4'h0 : val_q + 4'h1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= 4'h0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val = val_q;

endmodule

// File: rtl/io_entry_ctrl.sv
// User-I/O entry controller: builds address and write data one hex page at a
// time from key pulses and per-digit increment switches, then issues the
// operation on a valid/ready request channel and shows read data.
//
// state | meaning
// IDLE  | choose mode with mode_key; step_key starts entry (or CLEAR request)
// ADDR  | editing address page pg_q (1..APG)
// DATA  | editing data page pg_q (1..DPG), WRITE only; shown as page APG+pg_q
// REQ   | request held on req_* until req_ready
// WAIT  | READ accepted, waiting for rsp_valid
// SHOW  | displaying captured read data until a key is pressed
module io_entry_ctrl
  import io_entry_pkg::*;
#(
  parameter  int ADDR_W = 25,
  parameter  int DATA_W = 16,
  parameter  int NDIG   = 4,
  localparam int DISP_W = 4 * NDIG,
  localparam int APG    = (ADDR_W + DISP_W - 1) / DISP_W,
  localparam int DPG    = (DATA_W + DISP_W - 1) / DISP_W,
  localparam int PG_W   = $clog2(APG + DPG + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_key,
  input  logic              step_key,
  input  logic [NDIG-1:0]   inc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [1:0]        req_op,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        mode,
  output logic [PG_W-1:0]   page,
  output logic [DISP_W-1:0] disp,
  output logic              done
);

  localparam int NPG   = APG + DPG;
  localparam int NDIGT = NPG * NDIG;
  localparam int ADIG  = APG * NDIG;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [PG_W-1:0]   pg_q, pg_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic [NDIG-1:0]   inc_q;
  logic              clr_regs;

  logic [NDIG-1:0]   inc_edge;
  logic              edit_en;
  logic [PG_W-1:0]   page_out;
  logic [PG_W-1:0]   gpage;
  logic [3:0]        dig [NDIGT];
  logic [NDIGT-1:0]  dig_en;
  logic [DISP_W-1:0] page_vec [NPG];
  logic [DISP_W-1:0] disp_edit;
  logic [ADDR_W-1:0] addr_vec;
  logic [DATA_W-1:0] data_vec;

  assign inc_edge = inc & ~inc_q;
  assign edit_en  = (state_q == ADDR) || (state_q == DATA);

  // Global 1-based page number: address pages first, then data pages.
  always_comb begin
    page_out = '0;
    if (state_q == ADDR) begin
      page_out = pg_q;
    end else if (state_q == DATA) begin
      page_out = pg_q + PG_W'(APG);
    end
  end

  assign gpage = page_out - PG_W'(1);

  // Digit storage: each digit wraps at the value its slice of the word can hold.
  for (genvar g = 0; g < NDIGT; g++) begin : g_dig
    localparam int         PGI  = g / NDIG;
    localparam logic [3:0] MAXV = (g < ADIG) ? digit_maxv(ADDR_W, g)
                                             : digit_maxv(DATA_W, g - ADIG);
    assign dig_en[g] = edit_en && (gpage == PG_W'(PGI)) && inc_edge[g % NDIG];

    hex_digit_ctr #(
      .MAXV(MAXV)
    ) u_dig (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (dig_en[g]),
      .clr   (clr_regs),
      .val   (dig[g])
    );
  end

  for (genvar p = 0; p < NPG; p++) begin : g_page
    for (genvar i = 0; i < NDIG; i++) begin : g_pd
      assign page_vec[p][4*i +: 4] = dig[p*NDIG + i];
    end
  end

  for (genvar b = 0; b < ADDR_W; b++) begin : g_abit
    assign addr_vec[b] = dig[b/4][b%4];
  end

  for (genvar b = 0; b < DATA_W; b++) begin : g_dbit
    assign data_vec[b] = dig[ADIG + b/4][b%4];
  end

  // Digits of the page being edited.
  always_comb begin
    disp_edit = '0;
    for (int p = 0; p < NPG; p++) begin
      if (edit_en && (gpage == PG_W'(p))) begin
        disp_edit = page_vec[p];
      end
    end
  end

  // Next-state, page, mode, capture and done logic.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pg_d     = pg_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    clr_regs = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode_key) begin
          mode_d = next_mode(mode_q);
        end else if (step_key) begin
          if (mode_q == CLEAR) begin
            state_d = REQ;
          end else begin
            state_d = ADDR;
            pg_d    = PG_W'(1);
          end
        end
      end
      ADDR: begin
        if (mode_key) begin
          state_d = IDLE;
          pg_d    = '0;
        end else if (step_key) begin
          if (pg_q == PG_W'(APG)) begin
            if (mode_q == WRITE) begin
              state_d = DATA;
              pg_d    = PG_W'(1);
            end else begin
              state_d = REQ;
              pg_d    = '0;
            end
          end else begin
            pg_d = pg_q + PG_W'(1);
          end
        end
      end
      DATA: begin
        if (mode_key) begin
          state_d = IDLE;
          pg_d    = '0;
        end else if (step_key) begin
          if (pg_q == PG_W'(DPG)) begin
            state_d = REQ;
            pg_d    = '0;
          end else begin
            pg_d = pg_q + PG_W'(1);
          end
        end
      end
      REQ: begin
        if (req_ready) begin
          if (mode_q == READ) begin
            state_d = WAIT;
          end else begin
            state_d  = IDLE;
            done_d   = 1'b1;
            clr_regs = (mode_q == CLEAR);
          end
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          rdata_d = rsp_rdata;
          done_d  = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (step_key || mode_key) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pg_d    = '0;
      end
    endcase
  end

  // Control registers and increment-level history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= CLEAR;
      pg_q    <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pg_q    <= pg_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      inc_q   <= inc;
    end
  end

  assign req_valid = (state_q == REQ);
  assign req_op    = mode_q;
  assign req_addr  = addr_vec;
  assign req_wdata = (mode_q == WRITE) ? data_vec : '0;
  assign mode      = ((state_q == REQ) || (state_q == WAIT)) ? BUSY : mode_q;
  assign page      = page_out;
  assign disp      = (state_q == SHOW) ? DISP_W'(rdata_q) : disp_edit;
  assign done      = done_q;

endmodule

// File: tb/tb_io_entry_ctrl.sv
// Scoreboard bench for io_entry_ctrl: stimulus pushes expected requests and
// completions; a negedge monitor pops and compares them.
module tb_io_entry_ctrl;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int NDIG   = 4;
  localparam int DISP_W = 4 * NDIG;
  localparam int APG    = (ADDR_W + DISP_W - 1) / DISP_W;
  localparam int DPG    = (DATA_W + DISP_W - 1) / DISP_W;
  localparam int PG_W   = $clog2(APG + DPG + 1);

  localparam logic [1:0] M_CLR  = 2'b00;
  localparam logic [1:0] M_RD   = 2'b01;
  localparam logic [1:0] M_WR   = 2'b10;
  localparam logic [1:0] M_BUSY = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode_key = 1'b0;
  logic              step_key = 1'b0;
  logic [NDIG-1:0]   inc = '0;
  logic              req_ready = 1'b0;
  logic              rsp_valid = 1'b0;
  logic [DATA_W-1:0] rsp_rdata = '0;
  logic              req_valid;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        mode;
  logic [PG_W-1:0]   page;
  logic [DISP_W-1:0] disp;
  logic              done;

  io_entry_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .NDIG  (NDIG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_key  (mode_key),
    .step_key  (step_key),
    .inc       (inc),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mode      (mode),
    .page      (page),
    .disp      (disp),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] op;
    longint     addr;
    longint     wdata;
  } req_t;

  req_t   req_q[$];
  longint done_q[$];

  // Reference state: entered address/data words and selected mode.
  longint     m_addr;
  longint     m_data;
  logic [1:0] m_mode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_next(input logic [1:0] m);
    if (m == M_CLR) return M_WR;
    if (m == M_WR) return M_RD;
    return M_CLR;
  endfunction

  // Add one to the 4-bit field at bit pos of a total-bit word, wrapping within
  // however many bits of the field actually exist.
  function automatic longint bump(input longint v, input int total, input int pos);
    int w;
    longint m, f;
    w = total - pos;
    if (w > 4) w = 4;
    if (w <= 0) return v;
    m = (longint'(1) << w) - 1;
    f = (((v >> pos) & m) + 1) % (longint'(1) << w);
    return (v & ~(m << pos)) | (f << pos);
  endfunction

  function automatic void model_inc(input int gp, input int i);
    int g;
    g = gp * NDIG + i;
    if (g < APG * NDIG) m_addr = bump(m_addr, ADDR_W, 4 * g);
    else m_data = bump(m_data, DATA_W, 4 * (g - APG * NDIG));
  endfunction

  function automatic longint model_disp(input int gp);
    longint mask;
    mask = (longint'(1) << DISP_W) - 1;
    if (gp < APG) return (m_addr >> (DISP_W * gp)) & mask;
    return (m_data >> (DISP_W * (gp - APG))) & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    step_key = 1'b1;
    tick();
    step_key = 1'b0;
  endtask

  // Raise inc levels v for hold cycles, then release; model counts one edge per bit.
  task automatic press(input logic [NDIG-1:0] v, input int hold, input int gp, input bit apply);
    inc = v;
    repeat (hold) tick();
    inc = '0;
    tick();
    if (apply) begin
      for (int i = 0; i < NDIG; i++) if (v[i]) model_inc(gp, i);
    end
  endtask

  task automatic press_n(input logic [NDIG-1:0] v, input int n, input int gp);
    repeat (n) press(v, 1, gp, 1'b1);
  endtask

  task automatic goto_mode(input logic [1:0] target);
    while (m_mode != target) begin
      mode_key = 1'b1;
      tick();
      mode_key = 1'b0;
      m_mode = model_next(m_mode);
      chk("idle_mode", 64'(mode), 64'(m_mode));
      chk("idle_page", 64'(page), 64'd0);
      chk("idle_req_valid", 64'(req_valid), 64'd0);
    end
  endtask

  task automatic push_req();
    req_t r;
    r.op    = m_mode;
    r.addr  = m_addr;
    r.wdata = (m_mode == M_WR) ? m_data : 0;
    req_q.push_back(r);
  endtask

  task automatic accept(input int dly);
    for (int d = 0; d < dly; d++) begin
      tick();
      chk("req_valid_waiting", 64'(req_valid), 64'd1);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((done_q.size() + req_q.size()) != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", 64'(done_q.size() + req_q.size()), 64'd0);
  endtask

  task automatic read_rsp(input logic [DATA_W-1:0] rd, input int dly);
    chk("wait_mode", 64'(mode), 64'(M_BUSY));
    chk("wait_req_valid", 64'(req_valid), 64'd0);
    repeat (dly) tick();
    done_q.push_back(longint'(rd));
    rsp_rdata = rd;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("show_disp", 64'(disp), 64'(rd));
    chk("show_page", 64'(page), 64'd0);
    chk("show_mode", 64'(mode), 64'(M_RD));
    step();
    chk("after_show_mode", 64'(mode), 64'(M_RD));
    chk("after_show_disp", 64'(disp), 64'd0);
  endtask

  // One full randomized operation.
  task automatic run_op(input logic [1:0] op, input logic [DATA_W-1:0] rd,
                        input int rdy_dly, input int rsp_dly, input bit inc_in_req);
    int npg;
    goto_mode(op);
    step();
    if (op != M_CLR) begin
      npg = (op == M_WR) ? APG + DPG : APG;
      for (int p = 0; p < npg; p++) begin
        chk("edit_page", 64'(page), 64'(p + 1));
        chk("edit_mode", 64'(mode), 64'(op));
        repeat ($urandom_range(0, 3))
          press(NDIG'($urandom_range(1, (1 << NDIG) - 1)), $urandom_range(1, 2), p, 1'b1);
        chk("edit_disp", 64'(disp), 64'(model_disp(p)));
        step();
      end
    end
    chk("req_mode", 64'(mode), 64'(M_BUSY));
    chk("req_page", 64'(page), 64'd0);
    chk("req_valid", 64'(req_valid), 64'd1);
    if (inc_in_req) press(NDIG'($urandom_range(1, (1 << NDIG) - 1)), 1, 0, 1'b0);
    push_req();
    if (op != M_RD) done_q.push_back(0);
    accept(rdy_dly);
    if (op == M_CLR) begin
      m_addr = 0;
      m_data = 0;
    end
    if (op == M_RD) read_rsp(rd, rsp_dly);
    drain();
  endtask

  // Monitor: payload stability, request acceptance and completion pulses.
  req_t        mon_r;
  logic        prev_pend = 1'b0;
  logic        prev_done = 1'b0;
  logic [1:0]  prev_op;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pend = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("req_held", 64'(req_valid), 64'd1);
        chk("req_op_stable", 64'(req_op), 64'(prev_op));
        chk("req_addr_stable", 64'(req_addr), 64'(prev_addr));
        chk("req_wdata_stable", 64'(req_wdata), 64'(prev_wdata));
      end
      if (req_valid && req_ready) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: accept with 0 queued, required >=1 at %0t", $time);
        end else begin
          mon_r = req_q.pop_front();
          chk("req_op", 64'(req_op), 64'(mon_r.op));
          chk("req_addr", 64'(req_addr), mon_r.addr);
          chk("req_wdata", 64'(req_wdata), mon_r.wdata);
        end
      end
      prev_pend  = req_valid && !req_ready;
      prev_op    = req_op;
      prev_addr  = req_addr;
      prev_wdata = req_wdata;
      if (done) begin
        chk("done_width", 64'(prev_done), 64'd0);
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done with 0 queued, required >=1 at %0t", $time);
        end else begin
          chk("done_disp", 64'(disp), done_q.pop_front());
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal end");
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    m_addr = 0;
    m_data = 0;
    m_mode = M_CLR;

    #1;
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_page", 64'(page), 64'd0);
    chk("rst_disp", 64'(disp), 64'd0);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Mode rotation 10, 01, 00.
    goto_mode(M_RD);
    goto_mode(M_CLR);

    // Stray response while idle is ignored.
    rsp_valid = 1'b1;
    rsp_rdata = 16'h1234;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("stray_rsp_mode", 64'(mode), 64'(M_CLR));

    // Directed WRITE.
    goto_mode(M_WR);
    step();
    chk("w_page1", 64'(page), 64'd1);
    press_n(4'b0001, 3, 0);
    press_n(4'b1000, 1, 0);
    chk("w_page1_disp", 64'(disp), 64'h1003);
    step();
    chk("w_page2", 64'(page), 64'd2);
    press_n(4'b0001, 17, 1);
    chk("w_page2_wrap", 64'(disp), 64'h0001);
    press_n(4'b0100, 2, 1);
    press_n(4'b1000, 1, 1);
    chk("w_page2_topbit", 64'(disp), 64'h0001);
    step();
    chk("w_page3", 64'(page), 64'd3);
    press_n(4'b0100, 10, 2);
    chk("w_data_disp", 64'(disp), 64'h0A00);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("w_hold_valid", 64'(req_valid), 64'd1);
      chk("w_hold_addr", 64'(req_addr), 64'h0011003);
      chk("w_hold_wdata", 64'(req_wdata), 64'h0A00);
      chk("w_hold_op", 64'(req_op), 64'(M_WR));
      tick();
    end
    push_req();
    done_q.push_back(0);
    accept(0);
    drain();

    // Directed READ of the same address.
    goto_mode(M_RD);
    step();
    step();
    chk("r_page2_disp", 64'(disp), 64'(model_disp(1)));
    step();
    chk("r_req_addr", 64'(req_addr), 64'h0011003);
    push_req();
    accept(0);
    read_rsp(16'hBEEF, 7);
    drain();

    // Abort with both keys on address page 2.
    step();
    step();
    chk("abort_page2", 64'(page), 64'd2);
    mode_key = 1'b1;
    step_key = 1'b1;
    tick();
    mode_key = 1'b0;
    step_key = 1'b0;
    chk("abort_page", 64'(page), 64'd0);
    chk("abort_mode", 64'(mode), 64'(m_mode));
    chk("abort_req_valid", 64'(req_valid), 64'd0);
    step();
    chk("abort_addr_kept", 64'(disp), 64'(model_disp(0)));
    mode_key = 1'b1;
    tick();
    mode_key = 1'b0;
    chk("abort2_page", 64'(page), 64'd0);

    // CLEAR op with increments during REQ, then verify entry regs are zero.
    run_op(M_CLR, '0, 3, 0, 1'b1);
    goto_mode(M_WR);
    step();
    for (int p = 0; p < APG + DPG; p++) begin
      chk("clr_disp_zero", 64'(disp), 64'd0);
      if (p < APG + DPG - 1) step();
    end
    mode_key = 1'b1;
    tick();
    mode_key = 1'b0;

    // Randomized operations.
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 4))
        0:       op = M_CLR;
        1, 2:    op = M_WR;
        default: op = M_RD;
      endcase
      run_op(op, DATA_W'($urandom), $urandom_range(0, 4), $urandom_range(0, 6),
             1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while a request is pending.
    goto_mode(M_RD);
    repeat (APG + 1) step();
    chk("pre_rst_req_valid", 64'(req_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 64'(req_valid), 64'd0);
    chk("arst_mode", 64'(mode), 64'd0);
    chk("arst_page", 64'(page), 64'd0);
    chk("arst_disp", 64'(disp), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    m_addr = 0;
    m_data = 0;
    m_mode = M_CLR;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_mode", 64'(mode), 64'd0);
    chk("post_rst_req_valid", 64'(req_valid), 64'd0);
    goto_mode(M_WR);
    step();
    chk("post_rst_page", 64'(page), 64'd1);
    chk("post_rst_addr_zero", 64'(disp), 64'd0);
    mode_key = 1'b1;
    tick();
    mode_key = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
